// File: rtl/ant_maze_world.sv
// Maze environment for the ant agent: owns position, heading, pheromone map,
// step budget and escape/timeout status, and answers the agent's move commands.
module ant_maze_world #(
  parameter logic [63:0] MAZE      = 64'h0,
  parameter int unsigned START_X   = 0,
  parameter int unsigned START_Y   = 0,
  parameter logic [1:0]  START_DIR = 2'd1,
  parameter int unsigned EXIT_X    = 7,
  parameter int unsigned EXIT_Y    = 7,
  parameter int unsigned MAX_STEPS = 255,
  parameter int unsigned PH_WIDTH  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          move,
  input  logic [PH_WIDTH-1:0] ph_drop,
  output logic                ant_r,
  output logic                ant_l,
  output logic                hit,
  output logic                escape,
  output logic                timeout,
  output logic [PH_WIDTH-1:0] ph_detected,
  output logic [2:0]          pos_x,
  output logic [2:0]          pos_y,
  output logic [1:0]          dir,
  output logic [7:0]          steps
);

  localparam int unsigned CELLS = 64;
  localparam logic [2:0]  SX = 3'(START_X);
  localparam logic [2:0]  SY = 3'(START_Y);
  localparam logic [2:0]  EX = 3'(EXIT_X);
  localparam logic [2:0]  EY = 3'(EXIT_Y);
  localparam logic [7:0]  STEP_LIMIT = 8'(MAX_STEPS);
  localparam logic        START_AT_EXIT = (SX == EX) && (SY == EY);

  localparam logic [1:0] MV_HALT  = 2'd0;
  localparam logic [1:0] MV_RIGHT = 2'd1;
  localparam logic [1:0] MV_LEFT  = 2'd2;
  localparam logic [1:0] MV_FWD   = 2'd3;

  logic [PH_WIDTH-1:0] ph_map [CELLS];

  logic [6:0] ahead;
  logic [6:0] right_cell;
  logic [6:0] left_cell;
  logic       ahead_blk;
  logic [5:0] cur_cell;
  logic       active;
  logic       reach_exit;
  logic [7:0] steps_nx;

  // Neighbour of (cx,cy) in heading d, packed as {off_grid, y, x}.
  function automatic logic [6:0] step_cell(input logic [2:0] cx, input logic [2:0] cy,
                                           input logic [1:0] d);
    logic       off;
    logic [2:0] nx;
    logic [2:0] ny;
    off = 1'b0;
    nx  = cx;
    ny  = cy;
    case (d)
      2'd0: begin off = (cy == 3'd0); ny = cy - 3'd1; end
      2'd1: begin off = (cx == 3'd7); nx = cx + 3'd1; end
      2'd2: begin off = (cy == 3'd7); ny = cy + 3'd1; end
      default: begin off = (cx == 3'd0); nx = cx - 3'd1; end
    endcase
    return {off, ny, nx};
  endfunction

  // Sensor view of the registered state and next-step decode.
  always_comb begin
    ahead       = step_cell(pos_x, pos_y, dir);
    right_cell  = step_cell(pos_x, pos_y, dir + 2'd1);
    left_cell   = step_cell(pos_x, pos_y, dir - 2'd1);
    ahead_blk   = ahead[6] | MAZE[ahead[5:0]];
    ant_r       = right_cell[6] | MAZE[right_cell[5:0]];
    ant_l       = left_cell[6] | MAZE[left_cell[5:0]];
    cur_cell    = {pos_y, pos_x};
    ph_detected = ph_map[cur_cell];
    active      = !escape && !timeout;
    steps_nx    = steps + 8'd1;
    reach_exit  = (move == MV_FWD) && !ahead_blk && (ahead[2:0] == EX) && (ahead[5:3] == EY);
  end

  // World state; frozen once escaped or out of budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x   <= SX;
      pos_y   <= SY;
      dir     <= START_DIR;
      ph_map  <= '{default: '0};
      steps   <= 8'd0;
      hit     <= 1'b0;
      escape  <= START_AT_EXIT;
      timeout <= 1'b0;
    end else if (active) begin
      steps <= steps_nx;
      hit   <= 1'b0;
      if (ph_drop != '0) ph_map[cur_cell] <= ph_drop;
      case (move)
        MV_HALT:  ;
        MV_RIGHT: dir <= dir + 2'd1;
        MV_LEFT:  dir <= dir - 2'd1;
        default: begin
          if (ahead_blk) begin
            hit <= 1'b1;
          end else begin
            pos_x <= ahead[2:0];
            pos_y <= ahead[5:3];
          end
        end
      endcase
      // Escape takes priority over a budget expiring on the same edge.
      if (reach_exit) escape <= 1'b1;
      else if (steps_nx == STEP_LIMIT) timeout <= 1'b1;
    end else begin
      hit <= 1'b0;
    end
  end

endmodule

// File: doc/ant_maze_world.md
Name: ant_maze_world

Overview:
- Environment model that drives the sensor side of the ant agent interface and consumes its `move` and `ph_drop` commands.
- Holds an 8x8 maze, the ant's position and heading, a per-cell pheromone map, a step budget and the escape status.
- Sits between the agent under test and the testbench scoreboard. It is the responder end of the agent's move/sense protocol.

Parameters:
- MAZE, 64'h0, wall bitmap: bit index y*8+x is 1 for a wall cell.
- START_X, 0, reset column (0..7).
- START_Y, 0, reset row (0..7).
- START_DIR, 2'd1, reset heading: N=0, E=1, S=2, W=3.
- EXIT_X, 7, exit cell column.
- EXIT_Y, 7, exit cell row.
- MAX_STEPS, 255, cycle budget before timeout (1..255).
- PH_WIDTH, 2, pheromone value width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- move  in  2  agent command: HALT=0, RIGHT=1, LEFT=2, FORWARD=3.
- ph_drop  in  PH_WIDTH  pheromone to deposit at the current cell; 0 means none.
- ant_r  out  1  cell on the ant's right is a wall or off-grid.
- ant_l  out  1  cell on the ant's left is a wall or off-grid.
- hit  out  1  one-cycle pulse: the last FORWARD was blocked.
- escape  out  1  sticky; the ant has reached the exit.
- timeout  out  1  sticky; the step budget is exhausted.
- ph_detected  out  PH_WIDTH  pheromone stored at the ant's current cell.
- pos_x  out  3  current column.
- pos_y  out  3  current row.
- dir  out  2  current heading.
- steps  out  8  cycles consumed since reset.

Behaviour:
- Reset (rst=1 at a clk edge) takes effect that edge, including mid-run:
  - pos = (START_X, START_Y), dir = START_DIR.
  - All 64 pheromone cells = 0.
  - steps = 0; hit, escape, timeout = 0.
  - ant_r, ant_l, ph_detected recomputed from the reset state.
- Coordinates: x increases to the East, y increases to the South.
  - N step = y-1, E = x+1, S = y+1, W = x-1.
  - Any neighbour outside 0..7 counts as a wall. No wrap-around.
- Active flag: active = !escape && !timeout. When active=0 the state is frozen: move and ph_drop are ignored, hit=0, steps hold.
- Each edge with active=1, the sampled move is applied:
  - HALT: no change.
  - RIGHT: dir = dir+1 mod 4. LEFT: dir = dir-1 mod 4. Position unchanged.
  - FORWARD, ahead cell free: position advances. Ahead cell wall/off-grid: position holds and hit=1 for exactly that next cycle.
  - hit=0 after every other move.
- Pheromone: if ph_drop != 0, the cell occupied before the move is written with ph_drop (overwrite), in the same edge as the move.
- Registered outputs: ant_r, ant_l and ph_detected are combinational views of the registered state, so they reflect the post-move cell and heading in the cycle after the command edge. One-cycle sense latency.
- Same-cell case: after HALT or a turn with a drop, the next cycle's ph_detected equals the dropped value.
- steps increments by 1 on every active edge, whatever the move.
- Escape: entering (EXIT_X, EXIT_Y) sets escape=1 at that edge.
- Timeout: when steps becomes MAX_STEPS, timeout=1 at that edge.
- If both occur on the same edge, escape=1 and timeout=0 (escape wins).
- Start cell = exit cell: escape=1 immediately after reset.
- The start cell being a wall in MAZE is a configuration error; no checking is required.

Test Plan:
- Turning: MAZE=0, start (0,0), dir E. RIGHT -> next cycle dir=S, ant_r=1 (West off-grid), ant_l=0. Four RIGHTs -> dir=E again, steps=4.
- Blocking: start (0,0), dir N, FORWARD -> hit=1 for one cycle, pos stays (0,0). Then HALT -> hit=0. Wall at (1,0) with dir E: FORWARD -> hit=1.
- Pheromone: at (2,3), ph_drop=2 with HALT -> ph_detected=2 next cycle. ph_drop=1 with FORWARD E -> ph_detected=0 at (3,3); turn back and return to (2,3) -> ph_detected=1.
- Escape: exit (1,0), start (0,0), dir E, FORWARD -> escape=1, pos=(1,0). Further FORWARD/ph_drop -> pos, steps and the pheromone map are unchanged, hit=0.
- Timeout: MAX_STEPS=5, HALT every cycle -> timeout=1 after the 5th active edge, steps=5 held. Escape on that same edge -> escape=1, timeout=0.
- Reset mid-run: after moves and drops, rst=1 for one edge -> pos/dir at start values, steps=0, flags cleared, ph_detected=0 on every revisited cell.
